// File: rtl/fft_pkg.sv
// Shared constants and types for the 32-point FFT core and its result collector.
package fft_pkg;

  localparam int FFT_N     = 32;
  localparam int FFT_IN_W  = 11;
  localparam int FFT_ANS_W = 17;
  localparam int FFT_IDX_W = $clog2(FFT_N);

  typedef enum logic [1:0] {
    SYNC    = 2'd0,
    COLLECT = 2'd1,
    DRAIN   = 2'd2
  } coll_state_t;

endpackage

// File: rtl/fft_bin_regfile.sv
// Two N-deep banks (real / imaginary) with one bank-selected write port and a
// combinational read port returning the complex pair at one address.
module fft_bin_regfile
  import fft_pkg::*;
#(
  parameter int N = FFT_N,
  parameter int W = FFT_ANS_W
) (
  input  logic                 clk,
  input  logic                 i_we,
  input  logic                 i_sel_im,
  input  logic [$clog2(N)-1:0] i_waddr,
  input  logic [W-1:0]         i_wdata,
  input  logic [$clog2(N)-1:0] i_raddr,
  output logic [W-1:0]         o_re,
  output logic [W-1:0]         o_im
);

  logic [W-1:0] r_re [N];
  logic [W-1:0] r_im [N];

  // Storage is deliberately left unreset; contents are only read after a full frame is written.
  always_ff @(posedge clk) begin
    if (i_we) begin
      if (i_sel_im) r_im[i_waddr] <= i_wdata;
      else          r_re[i_waddr] <= i_wdata;
    end
  end

  assign o_re = r_re[i_raddr];
  assign o_im = r_im[i_raddr];

endmodule

// File: rtl/fft_result_collector.sv
// Captures the FFT's serial result stream (N real words, then N imaginary words)
// and re-presents it as complex bins on a valid/ready interface.
module fft_result_collector
  import fft_pkg::*;
#(
  parameter int N = FFT_N,
  parameter int W = FFT_ANS_W
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 finish,
  input  logic [W-1:0]         answer,
  output logic                 bin_valid_o,
  input  logic                 bin_ready_i,
  output logic [$clog2(N)-1:0] bin_idx_o,
  output logic [W-1:0]         bin_re_o,
  output logic [W-1:0]         bin_im_o,
  output logic                 frame_done_o,
  output logic                 overrun_o
);

  localparam int IW = $clog2(N);
  localparam int CW = IW + 1;

  coll_state_t   r_state;
  logic [CW-1:0] r_wcnt;
  logic [IW-1:0] r_rcnt;
  logic          r_first;
  logic          r_valid;
  logic          r_done;
  logic          r_ovr;

  logic          w_we;
  logic          w_sel_im;
  logic [IW-1:0] w_waddr;
  logic [W-1:0]  w_rd_re;
  logic [W-1:0]  w_rd_im;
  logic          w_xfer;

  assign w_we     = (r_state == COLLECT) && finish;
  assign w_sel_im = (r_wcnt >= CW'(N));
  assign w_waddr  = w_sel_im ? IW'(r_wcnt - CW'(N)) : IW'(r_wcnt);
  assign w_xfer   = r_valid && bin_ready_i;

  fft_bin_regfile #(
    .N (N),
    .W (W)
  ) u_regfile (
    .clk      (clk),
    .i_we     (w_we),
    .i_sel_im (w_sel_im),
    .i_waddr  (w_waddr),
    .i_wdata  (answer),
    .i_raddr  (r_rcnt),
    .o_re     (w_rd_re),
    .o_im     (w_rd_im)
  );

  // r_first masks the overrun check for the single cycle right after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= SYNC;
      r_wcnt  <= '0;
      r_rcnt  <= '0;
      r_first <= 1'b1;
      r_valid <= 1'b0;
      r_done  <= 1'b0;
      r_ovr   <= 1'b0;
    end else begin
      r_first <= 1'b0;
      r_done  <= 1'b0;
      case (r_state)
        SYNC: begin
          if (finish && !r_first) r_ovr <= 1'b1;
          if (!finish) r_state <= COLLECT;
        end
        COLLECT: begin
          if (finish) begin
            if (r_wcnt == CW'(2 * N - 1)) begin
              r_wcnt  <= '0;
              r_valid <= 1'b1;
              r_state <= DRAIN;
            end else begin
              r_wcnt <= r_wcnt + CW'(1);
            end
          end
        end
        DRAIN: begin
          if (finish) r_ovr <= 1'b1;
          if (w_xfer) begin
            if (r_rcnt == IW'(N - 1)) begin
              r_rcnt  <= '0;
              r_valid <= 1'b0;
              r_done  <= 1'b1;
              r_state <= SYNC;
            end else begin
              r_rcnt <= r_rcnt + IW'(1);
            end
          end
        end
        default: r_state <= SYNC;
      endcase
    end
  end

  assign bin_valid_o  = r_valid;
  assign bin_idx_o    = r_valid ? r_rcnt  : '0;
  assign bin_re_o     = r_valid ? w_rd_re : '0;
  assign bin_im_o     = r_valid ? w_rd_im : '0;
  assign frame_done_o = r_done;
  assign overrun_o    = r_ovr;

endmodule

// File: tb/tb_fft_result_collector.sv
// Self-checking bench for fft_result_collector: table of frame scenarios, directed
// overrun/reset sequences, and randomized frames against a bin scoreboard.
module tb_fft_result_collector;
  import fft_pkg::*;

  localparam int N  = FFT_N;
  localparam int W  = FFT_ANS_W;
  localparam int IW = FFT_IDX_W;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          finish = 1'b0;
  logic [W-1:0]  answer = '0;
  logic          bin_ready_i = 1'b0;
  logic          bin_valid_o;
  logic [IW-1:0] bin_idx_o;
  logic [W-1:0]  bin_re_o;
  logic [W-1:0]  bin_im_o;
  logic          frame_done_o;
  logic          overrun_o;

  always #5 clk = ~clk;

  fft_result_collector #(
    .N (N),
    .W (W)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .finish       (finish),
    .answer       (answer),
    .bin_valid_o  (bin_valid_o),
    .bin_ready_i  (bin_ready_i),
    .bin_idx_o    (bin_idx_o),
    .bin_re_o     (bin_re_o),
    .bin_im_o     (bin_im_o),
    .frame_done_o (frame_done_o),
    .overrun_o    (overrun_o)
  );

  typedef struct {
    int          idx;
    logic [W-1:0] re;
    logic [W-1:0] im;
  } bin_t;

  typedef struct {
    int pattern;     // 0: re=k, im=-k; 1: constants; 2: random
    int ga_pos;
    int ga_len;
    int gb_pos;
    int gb_len;
    int rmode;       // 0: ready=1; 1: toggle starting at 0; 2: random
    int pre_idle;    // extra idle cycles after frame_done before word 0
    int exp_cycles;  // drain length in cycles, -1 = not checked
  } vec_t;

  bin_t         exp_q[$];
  logic [W-1:0] fr_re [N];
  logic [W-1:0] fr_im [N];
  int           nvec = 0;
  int           nfail = 0;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    nvec++;
    if (act !== expv) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
    end
  endfunction

  // Scoreboard/protocol monitor, sampled mid-cycle.
  logic          prev_hold = 1'b0;
  logic          prev_final = 1'b0;
  logic [IW-1:0] h_idx;
  logic [W-1:0]  h_re;
  logic [W-1:0]  h_im;

  always @(negedge clk) begin
    bin_t e;
    if (!rst_n) begin
      prev_hold  = 1'b0;
      prev_final = 1'b0;
    end else begin
      if (prev_final || frame_done_o)
        chk("frame_done", 64'({frame_done_o, bin_valid_o}), 64'({prev_final, 1'b0}));
      if (!bin_valid_o)
        chk("idle_zero", 64'({bin_idx_o, bin_re_o, bin_im_o}), 64'(0));
      if (prev_hold)
        chk("hold_stable", 64'({bin_valid_o, bin_idx_o, bin_re_o, bin_im_o}),
            64'({1'b1, h_idx, h_re, h_im}));
      if (bin_valid_o && bin_ready_i) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_bin", 64'(1), 64'(0));
        end else begin
          e = exp_q.pop_front();
          chk("bin", 64'({bin_idx_o, bin_re_o, bin_im_o}), 64'({IW'(e.idx), e.re, e.im}));
        end
      end
      prev_hold  = bin_valid_o && !bin_ready_i;
      prev_final = bin_valid_o && bin_ready_i && (bin_idx_o == IW'(N - 1));
      h_idx = bin_idx_o;
      h_re  = bin_re_o;
      h_im  = bin_im_o;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic make_frame(input int pattern);
    for (int k = 0; k < N; k++) begin
      case (pattern)
        0:       begin fr_re[k] = W'(k);        fr_im[k] = W'(-k);        end
        1:       begin fr_re[k] = W'('h10000);  fr_im[k] = W'('h0FFFF);   end
        default: begin fr_re[k] = W'($urandom); fr_im[k] = W'($urandom);  end
      endcase
    end
  endtask

  task automatic push_frame();
    for (int k = 0; k < N; k++) exp_q.push_back('{k, fr_re[k], fr_im[k]});
  endtask

  task automatic send_frame(input int nwords, input int ga_pos, input int ga_len,
                            input int gb_pos, input int gb_len);
    for (int k = 0; k < nwords; k++) begin
      int g;
      g = (k == ga_pos) ? ga_len : ((k == gb_pos) ? gb_len : 0);
      for (int j = 0; j < g; j++) begin
        finish = 1'b0;
        answer = W'($urandom);
        tick();
      end
      finish = 1'b1;
      answer = (k < N) ? fr_re[k] : fr_im[k - N];
      tick();
    end
    finish = 1'b0;
    answer = '0;
  endtask

  // Entered in the cycle after the capture of the last word; returns in the frame_done cycle.
  task automatic drain(input int rmode, input int exp_cycles);
    int c;
    c = 0;
    chk("first_bin_valid", 64'(bin_valid_o), 64'(1));
    while (!frame_done_o && c < 400) begin
      case (rmode)
        0:       bin_ready_i = 1'b1;
        1:       bin_ready_i = (c % 2 == 1);
        default: bin_ready_i = 1'($urandom_range(0, 1));
      endcase
      tick();
      c++;
    end
    bin_ready_i = 1'b0;
    chk("frame_done_reached", 64'(frame_done_o), 64'(1));
    if (exp_cycles >= 0) chk("drain_cycles", 64'(c), 64'(exp_cycles));
  endtask

  task automatic do_reset(input logic fin_first);
    rst_n = 1'b0;
    #1;
    chk("reset_outputs",
        64'({bin_valid_o, bin_idx_o, bin_re_o, bin_im_o, frame_done_o, overrun_o}), 64'(0));
    tick();
    finish = fin_first;
    answer = W'($urandom);
    rst_n  = 1'b1;
    tick();
    finish = 1'b0;
    answer = '0;
    tick();
  endtask

  vec_t tbl [5];

  initial begin
    tbl[0] = '{0, -1, 0, -1, 0, 0, 0, 32};   // nominal
    tbl[1] = '{0, -1, 0, -1, 0, 1, 0, 64};   // backpressure
    tbl[2] = '{0, 11, 3, 32, 1, 0, 0, 32};   // gapped input
    tbl[3] = '{0, -1, 0, -1, 0, 0, 1, 32};   // word 0 two cycles after frame_done
    tbl[4] = '{1, -1, 0, -1, 0, 0, 0, 32};   // extreme constant values

    #2;
    do_reset(1'b0);

    for (int i = 0; i < 5; i++) begin
      make_frame(tbl[i].pattern);
      push_frame();
      repeat (tbl[i].pre_idle + 1) tick();
      send_frame(2 * N, tbl[i].ga_pos, tbl[i].ga_len, tbl[i].gb_pos, tbl[i].gb_len);
      drain(tbl[i].rmode, tbl[i].exp_cycles);
      chk("overrun_clear", 64'(overrun_o), 64'(0));
    end

    // Overrun: second frame streams in while the first is held undrained.
    make_frame(2);
    push_frame();
    tick();
    send_frame(2 * N, -1, 0, -1, 0);
    bin_ready_i = 1'b0;
    make_frame(2);
    send_frame(2 * N, -1, 0, -1, 0);
    chk("overrun_set", 64'(overrun_o), 64'(1));
    chk("held_bin0", 64'({bin_valid_o, bin_idx_o, bin_re_o, bin_im_o}),
        64'({1'b1, IW'(0), exp_q[0].re, exp_q[0].im}));
    drain(0, 32);
    chk("overrun_sticky", 64'(overrun_o), 64'(1));
    make_frame(2);
    push_frame();
    tick();
    send_frame(2 * N, -1, 0, -1, 0);
    drain(0, 32);
    chk("overrun_sticky2", 64'(overrun_o), 64'(1));

    // Reset release with finish already high: that word is discarded without overrun.
    do_reset(1'b1);
    chk("overrun_after_reset", 64'(overrun_o), 64'(0));

    // Reset mid-collect, then a clean frame of extreme values.
    make_frame(2);
    send_frame(41, -1, 0, -1, 0);
    do_reset(1'b0);
    make_frame(1);
    push_frame();
    tick();
    send_frame(2 * N, -1, 0, -1, 0);
    drain(0, 32);
    chk("overrun_after_midreset", 64'(overrun_o), 64'(0));

    // Randomized frames, gaps and backpressure; some are abandoned by a mid-drain reset.
    for (int r = 0; r < 20; r++) begin
      make_frame(2);
      push_frame();
      repeat ($urandom_range(1, 3)) tick();
      send_frame(2 * N, $urandom_range(1, 2 * N - 1), $urandom_range(0, 3),
                 $urandom_range(1, 2 * N - 1), $urandom_range(0, 3));
      if (r % 7 == 6) begin
        bin_ready_i = 1'b0;
        repeat ($urandom_range(1, 4)) tick();
        chk("pre_reset_valid", 64'(bin_valid_o), 64'(1));
        do_reset(1'b0);
        exp_q.delete();
      end else begin
        drain(2, -1);
        chk("overrun_random", 64'(overrun_o), 64'(0));
      end
    end

    repeat (3) tick();
    chk("queue_empty", 64'(exp_q.size()), 64'(0));
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/fft_result_collector.md
# fft_result_collector

Sink-side companion to the 32-point FFT core. It captures the serial result stream, 32 real words then 32 imaginary words, each qualified by `finish`. It re-pairs the words into complex bins and presents them one bin at a time on a valid/ready interface. Downstream consumers get `{index, re, im}` with backpressure; the FFT core itself cannot stall.

## Interface
Parameters:
- `N`, default 32: points per frame; words per frame = 2·N.
- `W`, default 17: result word width, two's complement, passed through bit-exact.

Ports:
- `clk`  in  1: single clock; all state on its rising edge.
- `rst_n`  in  1: reset, asynchronous, active-low.
- `finish`  in  1: result word valid this cycle (FFT output qualifier).
- `answer`  in  W: result word. Words 0..N-1 are real parts of bins 0..N-1; words N..2N-1 are imaginary parts.
- `bin_valid_o`  out  1: bin available.
- `bin_ready_i`  in  1: consumer accepts. Transfer occurs when valid and ready are both 1 at a rising edge.
- `bin_idx_o`  out  log2(N): bin index.
- `bin_re_o`  out  W: real part.
- `bin_im_o`  out  W: imaginary part.
- `frame_done_o`  out  1: one-cycle pulse after the last bin transfers.
- `overrun_o`  out  1: sticky. Set when any `finish` word is dropped; cleared only by reset.

## Operation
States:
- `SYNC`
  - Reset state. Waits for `finish`=0 for at least one cycle, then moves to `COLLECT`.
  - All words seen in `SYNC` are discarded.
  - A `finish` word seen in `SYNC` sets `overrun_o`, except in the first cycle after reset.
- `COLLECT`
  - Each cycle with `finish`=1 writes `answer` to re_mem[wcnt] while wcnt<N, or to im_mem[wcnt−N] otherwise. wcnt then increments.
  - `finish`=0 cycles (gaps) are allowed and neither write nor count.
  - Capturing word 2N−1 resets wcnt to 0 and moves to `DRAIN`.
- `DRAIN`
  - `bin_valid_o`=1. `bin_idx_o`=rcnt, `bin_re_o`=re_mem[rcnt], `bin_im_o`=im_mem[rcnt].
  - On transfer, rcnt increments.
  - On transfer of rcnt=N−1: rcnt resets to 0, `frame_done_o` pulses in the next cycle, and the state moves to `SYNC`.
  - Any `finish`=1 word in `DRAIN` is dropped and sets `overrun_o`. This includes a word in the final-transfer cycle.

Rules:
- Data path is bit-exact. No rounding, saturation or sign manipulation.
- `bin_re_o`, `bin_im_o` and `bin_idx_o` are 0 whenever `bin_valid_o`=0.
- Outputs are stable while valid=1 and ready=0.
- `bin_valid_o` never drops without a transfer.
- Counters wrap only under the state rules above; there is no modulo overflow path.

## Timing
- Reset values, asserted asynchronously: state `SYNC`, wcnt=rcnt=0, `bin_valid_o`=0, idx/re/im=0, `frame_done_o`=0, `overrun_o`=0. Memories are not reset.
- Capture latency:
  - `bin_valid_o` rises in the cycle following the edge that captures word 2N−1.
  - With ready held at 1, one bin transfers per cycle, so a drain takes exactly N cycles.
- `frame_done_o` is high for exactly the one cycle following the final transfer edge. `bin_valid_o` is 0 in that cycle.
- `SYNC` → `COLLECT` takes one cycle with `finish`=0. If `finish` is already 0 when `frame_done_o` is high, the next frame's word 0 may arrive in the cycle after `frame_done_o`.
- Reset mid-frame or mid-drain:
  - Immediate return to the reset values; partial frame contents are abandoned.
  - The first `finish` word after reset deassertion is accepted only once `finish` has been observed low.

## Structure
- Shared package `fft_pkg` holds:
  - constants `FFT_N`=32, `FFT_IN_W`=11, `FFT_ANS_W`=17;
  - derived `FFT_IDX_W`=5;
  - state enum `coll_state_t` = {`SYNC`, `COLLECT`, `DRAIN`}.
- One sub-module: `fft_bin_regfile`.
  - Two N×W register arrays.
  - Single write port selecting the re or im bank.
  - Single combinational read port returning the {re, im} pair.
- The top holds the FSM, counters and output gating.

## Test plan
- **Nominal frame.** Words re[k]=k and im[k]=−k (17'h1FFFF for k=1), `finish` contiguous, ready=1 → bins idx 0..31 over 32 consecutive cycles. The first bin appears the cycle after word 63; `frame_done_o` pulses the cycle after bin 31; `overrun_o`=0.
- **Backpressure.** Ready toggles 0/1 every cycle, starting at 0 → each bin is held for 2 cycles with data stable, and all 32 bins complete in 64 cycles; order and values match the nominal frame.
- **Gapped input.** `finish` goes low for 3 cycles between words 10/11 and for 1 cycle between words 31/32 → output identical to the nominal frame.
- **Overrun.** Ready=0 during drain while a second 64-word frame streams in → `overrun_o`=1 and stays 1. The held bin 0 is unchanged. After release, the first frame drains correctly. A third frame, sent after `finish` has been low, is captured correctly.
- **Reset mid-collect.** Reset asserted after word 40 → all outputs 0 immediately. A following full frame with re[k]=17'h10000 and im[k]=17'h0FFFF produces exactly those values for all 32 bins.
- **Back-to-back frames.** Ready=1 and the next frame's word 0 arrives 2 cycles after `frame_done_o` → captured without overrun, and its bins drain correctly.
